// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
// Combinational helpers only; no state lives here.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // Odd parity across data plus parity bit means the frame is intact.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length debounce for one raw PS/2 pin.
// Level flips after FILTER_LEN consecutive samples disagree with it; resets high.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = 8'd0;
        // Any sample matching the current level restarts the run.
        if (sync2_q != level_q) begin
            if (cnt_q == 8'(FILTER_LEN - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames, folds E0/F0 prefixes
// into flags and strobes one scancode per key event, or frame_err on a bad frame.
import ps2_pkg::*;

module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2dat,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_brk,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            clk_f;
    logic            dat_f;
    logic            clk_f_prev_q;
    logic            fall;

    ps2_state_e      state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic            ext_pend_q;
    logic            brk_pend_q;
    logic [7:0]      code_q;
    logic            code_ext_q;
    logic            code_brk_q;
    logic            code_valid_q;
    logic            frame_err_q;

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic            timeout_hit;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (ps2clk),
        .level_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (ps2dat),
        .level_o (dat_f)
    );

    assign fall = clk_f_prev_q & ~clk_f;

    // A falling edge in the same cycle always beats the abort.
    assign timeout_hit = (state_q != ST_IDLE) && !fall &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        to_cnt_d = '0;
        if (!fall && !timeout_hit && state_q != ST_IDLE) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_f_prev_q <= 1'b1;
            to_cnt_q     <= '0;
        end else begin
            clk_f_prev_q <= clk_f;
            to_cnt_q     <= to_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            code_q       <= 8'h00;
            code_ext_q   <= 1'b0;
            code_brk_q   <= 1'b0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (timeout_hit) begin
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
                ext_pend_q  <= 1'b0;
                brk_pend_q  <= 1'b0;
            end else if (fall) begin
                case (state_q)
                    ST_IDLE: begin
                        // A high start bit is line noise, not a frame.
                        if (!dat_f) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {dat_f, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_f;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (ps2_parity_ok(shift_q, par_q) && dat_f) begin
                            if (shift_q == PS2_PFX_EXT) begin
                                ext_pend_q <= 1'b1;
                            end else if (shift_q == PS2_PFX_BRK) begin
                                brk_pend_q <= 1'b1;
                            end else begin
                                code_q       <= shift_q;
                                code_ext_q   <= ext_pend_q;
                                code_brk_q   <= brk_pend_q;
                                code_valid_q <= 1'b1;
                                ext_pend_q   <= 1'b0;
                                brk_pend_q   <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_pend_q  <= 1'b0;
                            brk_pend_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign code       = code_q;
    assign code_ext   = code_ext_q;
    assign code_brk   = code_brk_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: directed frames queue their expected
// strobe; a negedge monitor pops and compares whenever the DUT strobes.
module tb_ps2_frame_rx;

    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int HALF = 40;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2clk;
    logic       ps2dat;
    logic [7:0] code;
    logic       code_ext;
    logic       code_brk;
    logic       code_valid;
    logic       frame_err;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2dat     (ps2dat),
        .code       (code),
        .code_ext   (code_ext),
        .code_brk   (code_brk),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (code_valid || frame_err)) begin
            if (code_valid && frame_err) check("both_strobes", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, code_valid, frame_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    check("code", {24'd0, code}, {24'd0, e.code});
                    check("code_ext", {31'd0, code_ext}, {31'd0, e.ext});
                    check("code_brk", {31'd0, code_brk}, {31'd0, e.brk});
                end
                if (e.cyc >= 0) begin
                    n_cmp++;
                    if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                        n_bad++;
                        $display("FAIL timeout_latency: strobe at cycle %0d, expected %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_code(input logic [7:0] c, input bit ext, input bit brk);
        exp_t e;
        e.is_err = 1'b0; e.code = c; e.ext = ext; e.brk = brk; e.cyc = -1;
        sb.push_back(e);
    endtask

    task automatic expect_err(input int at_cyc);
        exp_t e;
        e.is_err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.brk = 1'b0; e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    // glitch 1: short low pulse during the high phase; 2: short high pulse during the low phase
    task automatic send_bit(input logic v, input int glitch);
        @(negedge clk);
        ps2dat = v;
        if (glitch == 1) begin
            wait_cyc(10); ps2clk = 1'b0; wait_cyc(FL - 1); ps2clk = 1'b1; wait_cyc(HALF - 10 - (FL - 1));
        end else begin
            wait_cyc(HALF);
        end
        ps2clk = 1'b0;
        last_fall_cyc = cyc;
        if (glitch == 2) begin
            wait_cyc(10); ps2clk = 1'b1; wait_cyc(FL - 1); ps2clk = 1'b0; wait_cyc(HALF - 10 - (FL - 1));
        end else begin
            wait_cyc(HALF);
        end
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitchy);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(fr[i], !glitchy ? 0 : (i == 3) ? 1 : (i == 6) ? 2 : 0);
        end
        @(negedge clk);
        ps2dat = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        wait_cyc(20);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_code"}, {24'd0, code}, 32'd0);
        check({tag, "_ext"}, {31'd0, code_ext}, 32'd0);
        check({tag, "_brk"}, {31'd0, code_brk}, 32'd0);
        check({tag, "_valid"}, {31'd0, code_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        ps2clk = 1'b1;
        ps2dat = 1'b1;
        wait_cyc(3);
        #1 check_outputs_zero("in_reset");
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(20);
        check_outputs_zero("post_reset");

        // Plain make code
        expect_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 0, 11, 0);
        drain(900);

        // Extended break, then plain code with flags cleared
        expect_code(8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 0, 0, 11, 0);
        send_frame(8'hF0, 0, 0, 11, 0);
        send_frame(8'h75, 0, 0, 11, 0);
        drain(900);
        expect_code(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 0, 11, 0);
        drain(900);
        check("hold_code", {24'd0, code}, 32'h1C);

        // Parity error; outputs hold
        expect_err(-1);
        send_frame(8'h1C, 1, 0, 11, 0);
        drain(900);
        check("hold_after_err", {24'd0, code}, 32'h1C);

        // Error drops a pending break prefix
        expect_err(-1);
        send_frame(8'hF0, 0, 0, 11, 0);
        send_frame(8'h1C, 0, 1, 11, 0);
        drain(900);
        expect_code(8'h2A, 1'b0, 1'b0);
        send_frame(8'h2A, 0, 0, 11, 0);
        drain(900);

        // Sub-threshold glitches, idle (with data low) and mid-frame
        @(negedge clk);
        ps2dat = 1'b0;
        wait_cyc(10);
        ps2clk = 1'b0; wait_cyc(FL - 1); ps2clk = 1'b1;
        wait_cyc(20);
        ps2dat = 1'b1;
        wait_cyc(20);
        expect_code(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 0, 0, 11, 1);
        drain(900);

        // Truncated frame times out
        send_frame(8'h3C, 0, 0, 5, 0);
        expect_err(last_fall_cyc + FL + TO + 4);
        drain(900);
        expect_code(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 0, 0, 11, 0);
        drain(900);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check_outputs_zero("mid_reset");
        wait_cyc(3);
        reset  = 1'b0;
        ps2dat = 1'b1;
        wait_cyc(2 * TO);
        check_outputs_zero("after_mid_reset");
        expect_code(8'h16, 1'b0, 1'b0);
        send_frame(8'h16, 0, 0, 11, 0);
        drain(900);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
